uart_tx: RTL and testbench

UART transmitter: accepts parallel words over a valid/ready handshake and serialises them as asynchronous frames on `tx`. Frame format is start bit (0), DATA_BITS data bits LSB first, optional even parity, one stop bit (1). It sits beside `uart_rx` in the UART mux datapath and shares its bit-period convention: one bit lasts `baud_divisor + 1` clocks. A one-word holding register allows back-to-back frames with no idle gap.

---
 rtl/uart_tx.sv | 233 +++++++++++++++++++++++
 tb/tb_uart_tx.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- asynchronous serial transmitter with a one-word holding register.
//
// Frame: start bit (0), DATA_BITS data bits LSB first, optional even parity,
// one stop bit (1). One bit lasts baud_divisor+1 clocks; the divisor is
// sampled once per frame, when the frame starts.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined     -> PARITY state present, even parity bit before the stop bit
//   not defined -> start + data + stop only
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-low reset
//   baud_divisor in   bit period minus one, in clocks
//   in_valid     in   data_in holds a word to send
//   in_ready     out  holding register empty (registered)
//   data_in      in   word to transmit
//   tx           out  serial line, idle high (registered)
//   busy         out  frame in progress or word held (registered)
//   done_tick    out  one-cycle pulse on the last clock of a stop bit
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int DATA_BITS    = 8,
  parameter int COUNTER_BITS = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [COUNTER_BITS-1:0] baud_divisor,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_BITS-1:0]    data_in,
  output logic                    tx,
  output logic                    busy,
  output logic                    done_tick
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

  state_t                  state_q,     state_d;
  logic                    hold_full_q, hold_full_d;
  logic [DATA_BITS-1:0]    hold_data_q, hold_data_d;
  logic [DATA_BITS-1:0]    shift_q,     shift_d;
  logic [COUNTER_BITS-1:0] div_q,       div_d;
  logic [COUNTER_BITS-1:0] cnt_q,       cnt_d;
  logic [IDX_W-1:0]        bit_idx_q,   bit_idx_d;
  logic                    tx_q,        tx_d;
  logic                    busy_q,      busy_d;
  logic                    in_ready_q,  in_ready_d;
  logic                    done_q,      done_d;
`ifdef UART_TX_PARITY_EN
  logic                    parity_q,    parity_d;
`endif

  logic load_s;
  logic unload_s;
  logic start_frame_s;
  logic cnt_last_s;

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign in_ready  = in_ready_q;
  assign done_tick = done_q;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d       = state_q;
    hold_full_d   = hold_full_q;
    hold_data_d   = hold_data_q;
    shift_d       = shift_q;
    div_d         = div_q;
    cnt_d         = cnt_q;
    bit_idx_d     = bit_idx_q;
    tx_d          = tx_q;
`ifdef UART_TX_PARITY_EN
    parity_d      = parity_q;
`endif
    start_frame_s = 1'b0;
    unload_s      = 1'b0;
    load_s        = in_valid && in_ready_q;
    cnt_last_s    = (cnt_q == div_q);

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (hold_full_q) begin
          start_frame_s = 1'b1;
        end else begin
          cnt_d = '0;
        end
      end
      ST_START: begin
        if (cnt_last_s) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
          state_d   = ST_DATA;
        end else begin
          cnt_d = cnt_q + COUNTER_BITS'(1);
        end
      end
      ST_DATA: begin
        if (cnt_last_s) begin
          cnt_d = '0;
          if (bit_idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = ST_PARITY;
`else
            tx_d    = 1'b1;
            state_d = ST_STOP;
`endif
          end else begin
            // Next bit moves into position 0 of the shifter.
            shift_d   = shift_q >> 1'b1;
            tx_d      = shift_d[0];
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + COUNTER_BITS'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (cnt_last_s) begin
          cnt_d   = '0;
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + COUNTER_BITS'(1);
        end
      end
`endif
      ST_STOP: begin
        if (cnt_last_s) begin
          if (hold_full_q) begin
            // Chain straight into the next start bit, no idle gap.
            start_frame_s = 1'b1;
          end else begin
            cnt_d   = '0;
            tx_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + COUNTER_BITS'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase

    // Frame start: held word to shifter, divisor frozen for this frame.
    if (start_frame_s) begin
      unload_s  = 1'b1;
      shift_d   = hold_data_q;
      div_d     = baud_divisor;
      cnt_d     = '0;
      bit_idx_d = '0;
      tx_d      = 1'b0;
      state_d   = ST_START;
`ifdef UART_TX_PARITY_EN
      parity_d  = ^hold_data_q;
`endif
    end else begin
      unload_s  = 1'b0;
    end

    // A same-edge load wins over unload: the register stays full.
    if (load_s) begin
      hold_full_d = 1'b1;
      hold_data_d = data_in;
    end else if (unload_s) begin
      hold_full_d = 1'b0;
    end else begin
      hold_full_d = hold_full_q;
    end

    busy_d     = (state_d != ST_IDLE) || hold_full_d;
    in_ready_d = !hold_full_d;
    // Pulse on the clock that holds the final count of a stop bit.
    done_d     = (state_d == ST_STOP) && (cnt_d == div_d);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      shift_q     <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      done_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      shift_q     <= shift_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      done_q      <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx -- self-checking bench for uart_tx (DATA_BITS=8).
// Expected line waveforms are built per frame from the frame format:
// list of bit values, each repeated div+1 clocks, done on the final clock.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  localparam int DB = 8;
  localparam int CB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [CB-1:0] baud_divisor = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DB-1:0] data_in = '0;
  logic          tx;
  logic          busy;
  logic          done_tick;

  int checks = 0;
  int errors = 0;

  logic exp_tx_q[$];
  logic exp_done_q[$];

  uart_tx #(.DATA_BITS(DB), .COUNTER_BITS(CB)) dut (
    .clk(clk), .reset(reset), .baud_divisor(baud_divisor),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .tx(tx), .busy(busy), .done_tick(done_tick)
  );

  always #5 clk = ~clk;

  // Reference: append one frame's per-clock line level and done flag.
  function automatic void model_frame(input logic [DB-1:0] d, input int div);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) bits.push_back(d[i]);
    if (PAR == 1) bits.push_back(^d);
    bits.push_back(1'b1);
    for (int b = 0; b < bits.size(); b++)
      for (int c = 0; c <= div; c++) begin
        exp_tx_q.push_back(bits[b]);
        exp_done_q.push_back((b == bits.size() - 1) && (c == div));
      end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [DB-1:0] d);
    in_valid = 1'b1;
    data_in  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if (tx !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0 || done_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_state tx=%b rdy=%b busy=%b done=%b expected 1 1 0 0", tx, in_ready, busy, done_tick);
    end
    #2 reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      checks++;
      if (tx !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0 || done_tick !== 1'b0) begin
        errors++;
        $display("FAIL idle_cycle %0d tx=%b rdy=%b busy=%b done=%b expected 1 1 0 0", i, tx, in_ready, busy, done_tick);
      end
    end
  endtask

  task automatic test_a5();
    int done_cnt = 0;
    int done_at = -1;
    exp_tx_q.delete(); exp_done_q.delete();
    baud_divisor = 16'd3;
    model_frame(8'hA5, 3);
    send_word(8'hA5);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1 || tx !== 1'b1) begin
      errors++;
      $display("FAIL a5_held rdy=%b busy=%b tx=%b expected 0 1 1", in_ready, busy, tx);
    end
    for (int i = 0; i < exp_tx_q.size(); i++) begin
      tick();
      checks++;
      if (tx !== exp_tx_q[i] || done_tick !== exp_done_q[i] || busy !== 1'b1) begin
        errors++;
        $display("FAIL a5_wave clk %0d tx=%b done=%b busy=%b expected %b %b 1", i, tx, done_tick, busy, exp_tx_q[i], exp_done_q[i]);
      end
      if (done_tick === 1'b1) begin
        done_cnt++;
        done_at = i;
      end
    end
    checks++;
    if (done_cnt != 1 || done_at != (10 + PAR) * 4 - 1) begin
      errors++;
      $display("FAIL a5_done count=%0d at=%0d expected 1 at %0d", done_cnt, done_at, (10 + PAR) * 4 - 1);
    end
    tick();
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1 || done_tick !== 1'b0) begin
      errors++;
      $display("FAIL a5_after tx=%b busy=%b rdy=%b done=%b expected 1 0 1 0", tx, busy, in_ready, done_tick);
    end
  endtask

  task automatic test_back_to_back();
    int flen;
    logic exp_rdy;
    exp_tx_q.delete(); exp_done_q.delete();
    baud_divisor = 16'd0;
    model_frame(8'h00, 0);
    flen = exp_tx_q.size();
    model_frame(8'hFF, 0);
    in_valid = 1'b1;
    data_in  = 8'h00;
    tick();
    data_in  = 8'hFF;
    for (int i = 0; i < exp_tx_q.size(); i++) begin
      tick();
      if (i == 1) in_valid = 1'b0;
      checks++;
      if (tx !== exp_tx_q[i] || done_tick !== exp_done_q[i] || busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_wave clk %0d tx=%b done=%b busy=%b expected %b %b 1", i, tx, done_tick, busy, exp_tx_q[i], exp_done_q[i]);
      end
      // Second word accepted at the edge before sample 1, held until frame 1 ends.
      exp_rdy = !(i >= 1 && i <= flen - 1);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL b2b_ready clk %0d got %b expected %b", i, in_ready, exp_rdy);
      end
    end
    tick();
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_after tx=%b busy=%b expected 1 0", tx, busy);
    end
  endtask

  task automatic test_div_change();
    logic [DB-1:0] d1, d2;
    d1 = DB'($urandom);
    d2 = DB'($urandom);
    exp_tx_q.delete(); exp_done_q.delete();
    baud_divisor = 16'd3;
    model_frame(d1, 3);
    model_frame(d2, 7);
    send_word(d1);
    for (int i = 0; i < exp_tx_q.size(); i++) begin
      tick();
      if (i == 6) begin
        baud_divisor = 16'd7;
        in_valid = 1'b1;
        data_in  = d2;
      end else if (i == 7) begin
        in_valid = 1'b0;
      end
      checks++;
      if (tx !== exp_tx_q[i] || done_tick !== exp_done_q[i]) begin
        errors++;
        $display("FAIL divchg_wave clk %0d tx=%b done=%b expected %b %b", i, tx, done_tick, exp_tx_q[i], exp_done_q[i]);
      end
    end
    tick();
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL divchg_after tx=%b busy=%b expected 1 0", tx, busy);
    end
    baud_divisor = 16'd3;
  endtask

  task automatic test_reset_mid_frame();
    logic [DB-1:0] d3;
    int dv;
    exp_tx_q.delete(); exp_done_q.delete();
    baud_divisor = 16'd3;
    model_frame(8'h5A, 3);
    send_word(8'h5A);
    for (int i = 0; i < 18; i++) begin
      tick();
      if (i == 2) begin
        in_valid = 1'b1;
        data_in  = 8'hC3;
      end else if (i == 3) begin
        in_valid = 1'b0;
      end
      checks++;
      if (tx !== exp_tx_q[i]) begin
        errors++;
        $display("FAIL rstmid_wave clk %0d tx=%b expected %b", i, tx, exp_tx_q[i]);
      end
    end
    // Sample 17 lies inside data bit 3; drop reset between edges.
    #1 reset = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1 || done_tick !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async tx=%b busy=%b rdy=%b done=%b expected 1 0 1 0", tx, busy, in_ready, done_tick);
    end
    repeat (2) tick();
    #2 reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || done_tick !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_quiet clk %0d tx=%b busy=%b done=%b expected 1 0 0", i, tx, busy, done_tick);
      end
    end
    d3 = DB'($urandom);
    dv = int'($urandom_range(0, 3));
    baud_divisor = CB'(dv);
    exp_tx_q.delete(); exp_done_q.delete();
    model_frame(d3, dv);
    send_word(d3);
    for (int i = 0; i < exp_tx_q.size(); i++) begin
      tick();
      checks++;
      if (tx !== exp_tx_q[i] || done_tick !== exp_done_q[i]) begin
        errors++;
        $display("FAIL rstmid_next clk %0d tx=%b done=%b expected %b %b", i, tx, done_tick, exp_tx_q[i], exp_done_q[i]);
      end
    end
  endtask

  task automatic test_random_frames();
    logic [DB-1:0] d;
    int dv;
    for (int f = 0; f < 8; f++) begin
      d  = DB'($urandom);
      dv = int'($urandom_range(0, 4));
      baud_divisor = CB'(dv);
      exp_tx_q.delete(); exp_done_q.delete();
      model_frame(d, dv);
      send_word(d);
      for (int i = 0; i < exp_tx_q.size(); i++) begin
        tick();
        checks++;
        if (tx !== exp_tx_q[i] || done_tick !== exp_done_q[i]) begin
          errors++;
          $display("FAIL rand_wave frame %0d d=%h div=%0d clk %0d tx=%b done=%b expected %b %b", f, d, dv, i, tx, done_tick, exp_tx_q[i], exp_done_q[i]);
        end
      end
      repeat ($urandom_range(1, 5)) tick();
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL rand_idle frame %0d tx=%b busy=%b rdy=%b expected 1 0 1", f, tx, busy, in_ready);
      end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    exp_tx_q.delete(); exp_done_q.delete();
    baud_divisor = 16'd1;
    model_frame(8'h07, 1);
    send_word(8'h07);
    for (int i = 0; i < exp_tx_q.size(); i++) begin
      tick();
      checks++;
      if (tx !== exp_tx_q[i] || done_tick !== exp_done_q[i]) begin
        errors++;
        $display("FAIL parity_wave clk %0d tx=%b done=%b expected %b %b", i, tx, done_tick, exp_tx_q[i], exp_done_q[i]);
      end
      // Start (2) + eight data bits (16) puts the parity bit at clocks 18..19.
      if (i == 18 || i == 19) begin
        checks++;
        if (tx !== 1'b1) begin
          errors++;
          $display("FAIL parity_bit clk %0d tx=%b expected 1", i, tx);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_a5();
    test_back_to_back();
    test_div_change();
    test_reset_mid_frame();
    test_random_frames();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
